// File: rtl/usb_loopback_pkg.sv
// Shared types for the CY68013 slave-FIFO loopback sequencer.
// USB_PKTEND_EN adds the short-packet commit state to the FSM enum.
package usb_loopback_pkg;

   localparam logic [1:0] FIFOADDR_EP2 = 2'b00;
   localparam logic [1:0] FIFOADDR_EP4 = 2'b01;
   localparam logic [1:0] FIFOADDR_EP6 = 2'b10;
   localparam logic [1:0] FIFOADDR_EP8 = 2'b11;

   typedef enum logic {
      DIR_RD = 1'b0,
      DIR_WR = 1'b1
   } dir_e;

   typedef enum logic [3:0] {
      IDLE,
      RD_SEL,
      RD_OE,
      RD_STB,
      RD_GAP,
      RD_END,
      WR_SEL,
      WR_STB,
      WR_GAP,
      WR_END
`ifdef USB_PKTEND_EN
      , WR_PKTEND
`endif
   } state_e;

endpackage

// File: rtl/usb_loop_fifo.sv
// Single-clock first-word-fall-through FIFO holding the looped-back words.
// The head is read asynchronously so it is valid the cycle after a push.
module usb_loop_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 16
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             data_i,
   output logic [W-1:0]             head_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = DEPTH[AW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push, do_pop;

   assign do_push = push_i && (count_q != FULL_C);
   assign do_pop  = pop_i && (count_q != '0);

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/usb_loopback_ctrl.sv
// Slave-FIFO sequencer: drains EP2 into a word buffer and returns it via EP6.
// Define USB_PKTEND_EN to add the idle-timeout short-packet commit (usb_pktend).
module usb_loopback_ctrl
   import usb_loopback_pkg::*;
#(
   parameter int BUF_DEPTH = 16,
   parameter int BURST_MAX = 8
`ifdef USB_PKTEND_EN
   , parameter int PKTEND_TIMEOUT = 1024
`endif
) (
   input  logic                          fpga_gclk,
   input  logic                          reset,
   input  logic                          usb_flaga,
   input  logic                          usb_flagc,
   input  logic [15:0]                   usb_fd_i,
   output logic [15:0]                   usb_fd_o,
   output logic                          usb_fd_oe,
   output logic [1:0]                    usb_fifoaddr,
   output logic                          usb_slcs,
   output logic                          usb_sloe,
   output logic                          usb_slrd,
   output logic                          usb_slwr,
   output logic [$clog2(BUF_DEPTH):0]    buf_count,
   output logic                          busy
`ifdef USB_PKTEND_EN
   , output logic                        usb_pktend
`endif
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
   localparam logic [CW-1:0] BURST_C = CW'(BURST_MAX);

   state_e        state_q, state_d;
   dir_e          last_dir_q, last_dir_d;
   logic [CW-1:0] burst_q, burst_d;
   logic          push, pop, rd_ok, wr_ok;
   logic [15:0]   head;

   usb_loop_fifo #(.DEPTH(BUF_DEPTH), .W(16)) u_fifo (
      .clk_i   (fpga_gclk),
      .srst_i  (reset),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (usb_fd_i),
      .head_o  (head),
      .count_o (buf_count)
   );

   assign rd_ok = usb_flaga && (buf_count < DEPTH_C);
   assign wr_ok = usb_flagc && (buf_count != '0);
   assign push  = (state_q == RD_STB);
   assign pop   = (state_q == WR_STB);

`ifdef USB_PKTEND_EN
   localparam int TW = $clog2(PKTEND_TIMEOUT + 1);
   localparam logic [TW-1:0] PK_LAST = TW'(PKTEND_TIMEOUT - 1);

   logic [TW-1:0] idle_cnt_q, idle_cnt_d;
   logic          written_q, written_d;
   logic          pk_phase_q, pk_phase_d;
   logic          pk_idle;

   assign pk_idle = (buf_count == '0) && !usb_flaga && written_q;
`endif

   always_comb begin
      state_d    = state_q;
      last_dir_d = last_dir_q;
      burst_d    = burst_q;
`ifdef USB_PKTEND_EN
      idle_cnt_d = '0;
      written_d  = written_q | pop;
      pk_phase_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            burst_d = '0;
            // On a tie the direction not served last wins.
            if (rd_ok && (!wr_ok || last_dir_q == DIR_WR)) begin
               state_d    = RD_SEL;
               last_dir_d = DIR_RD;
            end else if (wr_ok) begin
               state_d    = WR_SEL;
               last_dir_d = DIR_WR;
            end
`ifdef USB_PKTEND_EN
            else if (pk_idle) begin
               if (idle_cnt_q == PK_LAST) state_d = WR_PKTEND;
               else                       idle_cnt_d = idle_cnt_q + 1'b1;
            end
`endif
         end
         RD_SEL: state_d = RD_OE;
         RD_OE:  state_d = RD_STB;
         RD_STB: begin
            burst_d = burst_q + 1'b1;
            state_d = RD_GAP;
         end
         RD_GAP: state_d = (burst_q < BURST_C && rd_ok) ? RD_STB : RD_END;
         RD_END: state_d = IDLE;
         WR_SEL: state_d = WR_STB;
         WR_STB: begin
            burst_d = burst_q + 1'b1;
            state_d = WR_GAP;
         end
         WR_GAP: state_d = (burst_q < BURST_C && wr_ok) ? WR_STB : WR_END;
         WR_END: state_d = IDLE;
`ifdef USB_PKTEND_EN
         WR_PKTEND: begin
            if (pk_phase_q) begin
               state_d   = IDLE;
               written_d = 1'b0;
            end else begin
               pk_phase_d = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Read and write windows are separated by RD_END / WR_END, where neither
   // the FPGA nor the CY68013 drives usb_fd.
   always_comb begin
      usb_slcs     = 1'b0;
      usb_fifoaddr = FIFOADDR_EP2;
      usb_sloe     = 1'b1;
      usb_slrd     = 1'b1;
      usb_slwr     = 1'b1;
      usb_fd_oe    = 1'b0;
      case (state_q)
         RD_OE, RD_GAP: usb_sloe = 1'b0;
         RD_STB: begin
            usb_sloe = 1'b0;
            usb_slrd = 1'b0;
         end
         WR_SEL, WR_GAP: begin
            usb_fifoaddr = FIFOADDR_EP6;
            usb_fd_oe    = 1'b1;
         end
         WR_STB: begin
            usb_fifoaddr = FIFOADDR_EP6;
            usb_fd_oe    = 1'b1;
            usb_slwr     = 1'b0;
         end
         WR_END: usb_fifoaddr = FIFOADDR_EP6;
`ifdef USB_PKTEND_EN
         WR_PKTEND: usb_fifoaddr = FIFOADDR_EP6;
`endif
         default: ;
      endcase
   end

   assign usb_fd_o = usb_fd_oe ? head : 16'h0000;
   assign busy     = (state_q != IDLE);

`ifdef USB_PKTEND_EN
   assign usb_pktend = !((state_q == WR_PKTEND) && pk_phase_q);
`endif

   always_ff @(posedge fpga_gclk) begin
      if (reset) begin
         state_q    <= IDLE;
         last_dir_q <= DIR_WR;
         burst_q    <= '0;
`ifdef USB_PKTEND_EN
         idle_cnt_q <= '0;
         written_q  <= 1'b0;
         pk_phase_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_dir_q <= last_dir_d;
         burst_q    <= burst_d;
`ifdef USB_PKTEND_EN
         idle_cnt_q <= idle_cnt_d;
         written_q  <= written_d;
         pk_phase_q <= pk_phase_d;
`endif
      end
   end

endmodule

// File: tb/tb_usb_loopback_ctrl.sv
// Directed bench: a CY68013 EP2/EP6 model around usb_loopback_ctrl.
module tb_usb_loopback_ctrl;

   logic        fpga_gclk = 1'b0;
   logic        reset;
   logic        usb_flaga;
   logic        usb_flagc;
   logic [15:0] usb_fd_i;
   logic [15:0] usb_fd_o;
   logic        usb_fd_oe;
   logic [1:0]  usb_fifoaddr;
   logic        usb_slcs;
   logic        usb_sloe;
   logic        usb_slrd;
   logic        usb_slwr;
   logic [4:0]  buf_count;
   logic        busy;
`ifdef USB_PKTEND_EN
   logic        usb_pktend;
`endif

   always #5 fpga_gclk = ~fpga_gclk;

   usb_loopback_ctrl dut (
      .fpga_gclk    (fpga_gclk),
      .reset        (reset),
      .usb_flaga    (usb_flaga),
      .usb_flagc    (usb_flagc),
      .usb_fd_i     (usb_fd_i),
      .usb_fd_o     (usb_fd_o),
      .usb_fd_oe    (usb_fd_oe),
      .usb_fifoaddr (usb_fifoaddr),
      .usb_slcs     (usb_slcs),
      .usb_sloe     (usb_sloe),
      .usb_slrd     (usb_slrd),
      .usb_slwr     (usb_slwr),
      .buf_count    (buf_count),
      .busy         (busy)
`ifdef USB_PKTEND_EN
      , .usb_pktend (usb_pktend)
`endif
   );

   // Host-side endpoint model: EP2 supplies words, EP6 collects them.
   logic [15:0] ep2_mem [64];
   logic [15:0] ep6_mem [64];
   int          ep2_len = 0;
   int          ep2_idx = 0;
   int          ep6_len = 0;
   logic        flaga_en;

   assign usb_flaga = flaga_en && (ep2_idx < ep2_len);
   assign usb_fd_i  = ep2_mem[ep2_idx[5:0]];

   logic        rd_hit, wr_hit;
   logic [15:0] wr_data;
   int          rd_run = 0, wr_run = 0, max_rd_run = 0, max_wr_run = 0;
   int          wr_bursts = 0, overlap_cnt = 0;

   always @(posedge fpga_gclk) begin
      rd_hit  <= !usb_slrd;
      wr_hit  <= !usb_slwr;
      wr_data <= usb_fd_o;
   end

   always @(negedge fpga_gclk) begin
      if (rd_hit) begin
         ep2_idx <= ep2_idx + 1;
         rd_run  <= rd_run + 1;
         if (rd_run + 1 > max_rd_run) max_rd_run <= rd_run + 1;
      end else if (!busy) begin
         rd_run <= 0;
      end
      if (wr_hit) begin
         ep6_mem[ep6_len[5:0]] <= wr_data;
         ep6_len <= ep6_len + 1;
         wr_run  <= wr_run + 1;
         if (wr_run == 0) wr_bursts <= wr_bursts + 1;
         if (wr_run + 1 > max_wr_run) max_wr_run <= wr_run + 1;
      end else if (!busy) begin
         wr_run <= 0;
      end
      if ((usb_fd_oe && !usb_sloe) || (!usb_slrd && !usb_slwr)) overlap_cnt <= overlap_cnt + 1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic add_ep2(input logic [15:0] w);
      ep2_mem[ep2_len[5:0]] = w;
      ep2_len++;
   endtask

   logic [10:1] slrd_exp, sloe_exp, busy_exp;
   logic [15:0] exp_w;
   int          base, wb0, nstb;

   initial begin
      reset     = 1'b1;
      usb_flagc = 1'b0;
      flaga_en  = 1'b0;
      repeat (3) @(negedge fpga_gclk);

      check("rst_slcs", usb_slcs, 0);
      check("rst_sloe", usb_sloe, 1);
      check("rst_slrd", usb_slrd, 1);
      check("rst_slwr", usb_slwr, 1);
      check("rst_fifoaddr", usb_fifoaddr, 0);
      check("rst_fd_oe", usb_fd_oe, 0);
      check("rst_fd_o", usb_fd_o, 0);
      check("rst_buf_count", buf_count, 0);
      check("rst_busy", busy, 0);

      reset = 1'b0;
      @(negedge fpga_gclk);

      // Read only: three words, EP6 full.
      add_ep2(16'h1111);
      add_ep2(16'h2222);
      add_ep2(16'h3333);
      flaga_en = 1'b1;
      slrd_exp = 10'b1110101011;
      sloe_exp = 10'b1100000001;
      busy_exp = 10'b0111111111;
      for (int c = 1; c <= 10; c++) begin
         @(negedge fpga_gclk);
         check($sformatf("rd_slrd_c%0d", c), usb_slrd, slrd_exp[c]);
         check($sformatf("rd_sloe_c%0d", c), usb_sloe, sloe_exp[c]);
         check($sformatf("rd_busy_c%0d", c), busy, busy_exp[c]);
         check($sformatf("rd_slwr_c%0d", c), usb_slwr, 1);
      end
      check("rd_buf_count", buf_count, 3);

      // Loopback: 20 more words with EP6 open.
      for (int i = 0; i < 20; i++) add_ep2(16'hA000 + 16'(i));
      usb_flagc = 1'b1;
      for (int i = 0; i < 1000 && ep6_len < 23; i++) @(negedge fpga_gclk);
      repeat (10) @(negedge fpga_gclk);
      check("lb_ep6_len", ep6_len, 23);
      for (int i = 0; i < 23; i++) begin
         if (i == 0)      exp_w = 16'h1111;
         else if (i == 1) exp_w = 16'h2222;
         else if (i == 2) exp_w = 16'h3333;
         else             exp_w = 16'hA000 + 16'(i - 3);
         check($sformatf("lb_word%0d", i), ep6_mem[i], exp_w);
      end
      check("lb_buf_count", buf_count, 0);
      check("lb_ep2_idx", ep2_idx, 23);
      check("lb_max_rd_burst", max_rd_run, 8);
      check("lb_max_wr_burst", max_wr_run, 8);

      // Full: EP6 closed, 20 words offered, only 16 fit.
      usb_flagc = 1'b0;
      for (int i = 0; i < 20; i++) add_ep2(16'hB000 + 16'(i));
      repeat (80) @(negedge fpga_gclk);
      check("full_buf_count", buf_count, 16);
      check("full_flaga", usb_flaga, 1);
      check("full_busy", busy, 0);
      check("full_slrd", usb_slrd, 1);
      check("full_ep2_idx", ep2_idx, 39);
      flaga_en  = 1'b0;
      usb_flagc = 1'b1;
      wb0  = wr_bursts;
      base = ep6_len;
      for (int i = 0; i < 500 && ep6_len < base + 16; i++) @(negedge fpga_gclk);
      repeat (10) @(negedge fpga_gclk);
      check("full_ep6_len", ep6_len, base + 16);
      for (int i = 0; i < 16; i++)
         check($sformatf("full_word%0d", i), ep6_mem[base + i], 16'hB000 + 16'(i));
      check("full_wr_bursts", wr_bursts - wb0, 2);
      check("full_drained", buf_count, 0);

      // Flag drop: EP6 goes full during the third write strobe.
      usb_flagc = 1'b0;
      flaga_en  = 1'b1;
      repeat (30) @(negedge fpga_gclk);
      check("drop_prefill", buf_count, 4);
      base = ep6_len;
      usb_flagc = 1'b1;
      nstb = 0;
      for (int i = 0; i < 40 && nstb < 3; i++) begin
         @(negedge fpga_gclk);
         if (!usb_slwr) nstb++;
      end
      usb_flagc = 1'b0;
      check("drop_third_strobe", nstb, 3);
      repeat (10) @(negedge fpga_gclk);
      check("drop_ep6_len", ep6_len, base + 3);
      check("drop_buf_count", buf_count, 1);
      check("drop_busy", busy, 0);
      for (int i = 0; i < 3; i++)
         check($sformatf("drop_word%0d", i), ep6_mem[base + i], 16'hB010 + 16'(i));
      usb_flagc = 1'b1;
      repeat (20) @(negedge fpga_gclk);
      check("resume_ep6_len", ep6_len, base + 4);
      check("resume_word", ep6_mem[base + 3], 16'hB013);
      check("resume_buf_count", buf_count, 0);

      // Reset during the second read strobe.
      usb_flagc = 1'b0;
      for (int i = 0; i < 4; i++) add_ep2(16'hC000 + 16'(i));
      nstb = 0;
      for (int i = 0; i < 40 && nstb < 2; i++) begin
         @(negedge fpga_gclk);
         if (!usb_slrd) nstb++;
      end
      check("mid_second_strobe", nstb, 2);
      check("mid_buf_count", buf_count, 1);
      reset = 1'b1;
      @(negedge fpga_gclk);
      check("mid_rst_slrd", usb_slrd, 1);
      check("mid_rst_slwr", usb_slwr, 1);
      check("mid_rst_sloe", usb_sloe, 1);
      check("mid_rst_fd_oe", usb_fd_oe, 0);
      check("mid_rst_buf_count", buf_count, 0);
      check("mid_rst_busy", busy, 0);
      flaga_en = 1'b0;
      reset    = 1'b0;
      repeat (5) @(negedge fpga_gclk);

      check("bus_overlap", overlap_cnt, 0);
      check("end_max_rd_burst", max_rd_run, 8);
      check("end_max_wr_burst", max_wr_run, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
